clfsr_keygen: RTL and testbench
===============================

# clfsr_keygen

Chaotic keystream generator that sits directly upstream of the image encryption stage. It combines a 32-bit Galois LFSR with a 16-bit fixed-point tent map. After a seeded warm-up, it emits one fresh R/G/B key byte triple per clock, with `Key_ready` held high for exactly `NUM_BYTES` consecutive cycles. The consumer adds one key triple to each pixel per cycle with no back-pressure, so this block never stalls mid-stream.

## Interface

Parameters:
- `NUM_BYTES`, default 16384: keystream length in cycles; must be ≥1.
- `WARMUP`, default 64: discarded iterations before streaming; must be ≥1.

Ports:
- `clk` — input, 1 bit: clock.
- `rst` — input, 1 bit: reset; synchronous, active-high.
- `start` — input, 1 bit: begin a run; sampled only in IDLE or DONE.
- `seed_lfsr` — input, 32 bits: LFSR seed, captured on the accepted `start`.
- `seed_x` — input, 16 bits: tent-map seed, captured on the accepted `start`.
- `R_random` — output, 8 bits: red key byte.
- `G_random` — output, 8 bits: green key byte.
- `B_random` — output, 8 bits: blue key byte.
- `Key_ready` — output, 1 bit: key bytes valid; advances every cycle while high.
- `busy` — output, 1 bit: high in WARMUP or STREAM.
- `key_done` — output, 1 bit: high in DONE.

## Operation

**States:** IDLE, WARMUP, STREAM, DONE. All outputs are derived from state and registers.
- `Key_ready` = (state==STREAM).
- `busy` = WARMUP or STREAM.
- `key_done` = DONE.

**IDLE / DONE:**
- `start`=1 loads `lfsr`←`seed_lfsr` and `x`←`seed_x`, clears `cnt`, and moves to WARMUP.
- Seed substitution: a `seed_lfsr` of 0 is loaded as 32'h00000001; a `seed_x` of 0 is loaded as 16'h0001.

**Step (one per clock in WARMUP and STREAM), using old values on the right-hand side:**
- `t` = `x[15] ? ~{x[14:0],1'b0} : {x[14:0],1'b0}`.
- `x_next` = `t ^ lfsr[15:0]`; if `x_next`==0, `x_next`=16'h0001.
- `lfsr_next` = `lfsr[0] ? ((lfsr>>1) ^ 32'h80200003) : (lfsr>>1)`.

**WARMUP:**
- Step and increment `cnt`.
- When `cnt`==`WARMUP`-1, go to STREAM with `cnt`←0.

**STREAM:**
- Step and increment `cnt`.
- When `cnt`==`NUM_BYTES`-1, go to DONE.

**Outputs:**
- While `Key_ready`=1, outputs are combinational from the current registers:
  - `R_random` = `x[7:0] ^ lfsr[23:16]`
  - `G_random` = `x[15:8] ^ lfsr[31:24]`
  - `B_random` = `x[7:0] ^ x[15:8] ^ lfsr[7:0]`
- Otherwise `R_random`, `G_random` and `B_random` are 8'h00.

**Counter:** `cnt` is wide enough for `max(NUM_BYTES, WARMUP)`, e.g. 15 bits at default parameters; it never wraps within a run.

**`start` handling:**
- `start` in WARMUP or STREAM is ignored.
- `start` in DONE restarts with new seeds; DONE→WARMUP in one edge.

## Timing

- **Reset:** `rst`=1 at an edge forces IDLE, `lfsr`=0, `x`=0 and `cnt`=0. All outputs read 0 in the following cycle, including a reset mid-STREAM, after which `Key_ready` is low the next cycle.
- **Start latency:** `start` accepted at edge E0 → `Key_ready` rises after edge E(`WARMUP`), so the first key triple reflects exactly `WARMUP` steps from the seeds.
- **Stream length:** `Key_ready` stays high for exactly `NUM_BYTES` cycles with no gaps. Each cycle's triple is consumed at the same edge that advances the generator.
- **End of stream:** at the final STREAM edge the state goes to DONE. `Key_ready` falls and `key_done` rises in the same cycle.
- **`rst` and `start` together:** `rst` wins and the block stays in IDLE.
- **Determinism:** identical seeds and parameters must yield a bit-identical keystream on every run.

## Test plan

1. **Reset values:** hold `rst` 3 cycles, then release with `start`=0 → all outputs 0 and the block stays in IDLE indefinitely.
2. **First steps:** `WARMUP`=1, `seed_lfsr`=1, `seed_x`=1, pulse `start`.
   - `Key_ready` rises 1 cycle after the `start` edge.
   - First triple R/G/B = 8'h23 / 8'h80 / 8'h00.
   - Next cycle R/G/B = 8'h35 / 8'hC0 / 8'h07.
3. **Defaults, full run:** default parameters, arbitrary seeds.
   - `Key_ready` rises 64 cycles after `start` and stays high exactly 16384 cycles.
   - `key_done` rises in the cycle `Key_ready` falls.
   - The stream matches the reference model byte-for-byte.
4. **Zero seeds:** `seed_lfsr`=0, `seed_x`=0 → keystream identical to `seed_lfsr`=1, `seed_x`=1.
5. **Ignored start and restart:**
   - Pulse `start` mid-STREAM with different seeds → stream unchanged and length still 16384.
   - Pulse `start` in DONE → a new run begins, and the same seeds reproduce the identical stream.
6. **Reset mid-stream:** assert `rst` at stream cycle 100 → `Key_ready`=0 and key bytes 0 next cycle. A subsequent `start` gives a full-length stream identical to a clean run.

Source files
------------

// File: rtl/clfsr_keygen.sv
// Chaotic keystream generator: 32-bit Galois LFSR coupled to a 16-bit tent map,
// seeded warm-up then one R/G/B key triple per clock for NUM_BYTES cycles.
module clfsr_keygen #(
  parameter int NUM_BYTES = 16384,
  parameter int WARMUP    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed_lfsr,
  input  logic [15:0] seed_x,
  output logic [7:0]  R_random,
  output logic [7:0]  G_random,
  output logic [7:0]  B_random,
  output logic        Key_ready,
  output logic        busy,
  output logic        key_done
);

  localparam int MAXC = (NUM_BYTES > WARMUP) ? NUM_BYTES : WARMUP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] W_LAST = CW'(WARMUP - 1);
  localparam logic [CW-1:0] S_LAST = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_lfsr;
  logic [15:0]     r_x;
  logic [CW-1:0]   r_cnt;
  logic            w_load;
  logic            w_step;
  logic            w_cnt_clr;

  logic [15:0]     w_t;
  logic [15:0]     w_x_mix;
  logic [15:0]     w_x_step;
  logic [31:0]     w_lfsr_step;
  logic [31:0]     w_seed_lfsr;
  logic [15:0]     w_seed_x;

  // Tent map folds on the MSB; zero is an absorbing state so it is kicked to 1.
  assign w_t         = r_x[15] ? ~{r_x[14:0], 1'b0} : {r_x[14:0], 1'b0};
  assign w_x_mix     = w_t ^ r_lfsr[15:0];
  assign w_x_step    = (w_x_mix == 16'h0000) ? 16'h0001 : w_x_mix;
  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ 32'h80200003) : (r_lfsr >> 1);
  assign w_seed_lfsr = (seed_lfsr == 32'h0) ? 32'h00000001 : seed_lfsr;
  assign w_seed_x    = (seed_x == 16'h0) ? 16'h0001 : seed_x;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_cnt_clr   = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        w_step = 1'b1;
        if (r_cnt == W_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_step = 1'b1;
        if (r_cnt == S_LAST) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lfsr  <= 32'h0;
      r_x     <= 16'h0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_lfsr <= w_seed_lfsr;
        r_x    <= w_seed_x;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_lfsr <= w_lfsr_step;
        r_x    <= w_x_step;
        r_cnt  <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      end
    end
  end

  assign Key_ready = (r_state == ST_STREAM);
  assign busy      = (r_state == ST_WARMUP) || (r_state == ST_STREAM);
  assign key_done  = (r_state == ST_DONE);

  assign R_random = Key_ready ? (r_x[7:0] ^ r_lfsr[23:16]) : 8'h00;
  assign G_random = Key_ready ? (r_x[15:8] ^ r_lfsr[31:24]) : 8'h00;
  assign B_random = Key_ready ? (r_x[7:0] ^ r_x[15:8] ^ r_lfsr[7:0]) : 8'h00;

endmodule

// File: tb/tb_clfsr_keygen.sv
// Directed bench for clfsr_keygen: hand-computed first steps on a short instance,
// full-length streams against a behavioural model on a default instance.
module tb_clfsr_keygen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic [31:0] seed_lfsr = 32'h0;
  logic [15:0] seed_x = 16'h0;
  logic [7:0]  R_random, G_random, B_random;
  logic        Key_ready, busy, key_done;

  logic        start1 = 1'b0;
  logic [31:0] seed_lfsr1 = 32'h0;
  logic [15:0] seed_x1 = 16'h0;
  logic [7:0]  R1, G1, B1;
  logic        kr1, busy1, done1;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_lfsr;
  logic [15:0] m_x;
  logic [31:0] csum_a, csum_b;

  always #5 clk = ~clk;

  clfsr_keygen dut (
    .clk(clk), .rst(rst), .start(start), .seed_lfsr(seed_lfsr), .seed_x(seed_x),
    .R_random(R_random), .G_random(G_random), .B_random(B_random),
    .Key_ready(Key_ready), .busy(busy), .key_done(key_done)
  );

  clfsr_keygen #(.NUM_BYTES(4), .WARMUP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .seed_lfsr(seed_lfsr1), .seed_x(seed_x1),
    .R_random(R1), .G_random(G1), .B_random(B1),
    .Key_ready(kr1), .busy(busy1), .key_done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference step written directly from the algorithm description.
  task automatic mstep();
    logic [15:0] t;
    logic [15:0] xn;
    logic        lsb;
    t = m_x << 1;
    if (m_x[15]) t = ~t;
    xn = t ^ m_lfsr[15:0];
    if (xn == 16'h0) xn = 16'h1;
    lsb = m_lfsr[0];
    m_lfsr = m_lfsr >> 1;
    if (lsb) m_lfsr = m_lfsr ^ 32'h80200003;
    m_x = xn;
  endtask

  // One run on the default instance. inj_start / inj_rst give the stream index
  // (bytes already consumed) at which to pulse start or rst; -1 disables.
  task automatic run(input logic [31:0] sl, input logic [15:0] sx,
                     input logic [31:0] ml, input logic [15:0] mx,
                     input int inj_start, input int inj_rst,
                     output logic [31:0] csum);
    int k, len, mism;
    logic [7:0] er, eg, eb;
    m_lfsr = ml;
    m_x = mx;
    for (int i = 0; i < 64; i++) mstep();
    seed_lfsr = sl;
    seed_x = sx;
    start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end while (!Key_ready && k < 200);
    // Accepted at the first edge, 64 warm-up edges, visible at the following negedge.
    check("start_latency", 32'(k), 32'd65);
    len = 0;
    mism = 0;
    csum = 32'h0;
    while (Key_ready && len < 20000) begin
      er = m_x[7:0] ^ m_lfsr[23:16];
      eg = m_x[15:8] ^ m_lfsr[31:24];
      eb = m_x[7:0] ^ m_x[15:8] ^ m_lfsr[7:0];
      if ({R_random, G_random, B_random} !== {er, eg, eb}) mism++;
      if (busy !== 1'b1) mism++;
      csum = {csum[30:0], csum[31]} ^ {8'h00, R_random, G_random, B_random};
      mstep();
      len++;
      if (len == inj_start) begin
        seed_lfsr = ~sl;
        seed_x = ~sx;
        start = 1'b1;
      end
      if (len == inj_rst) rst = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (len == inj_rst) begin
        check("rst_mid_ready", 32'(Key_ready), 32'd0);
        check("rst_mid_bytes", {8'h00, R_random, G_random, B_random}, 32'h0);
        check("rst_mid_flags", {30'h0, busy, key_done}, 32'h0);
        rst = 1'b0;
        return;
      end
    end
    check("stream_mismatches", 32'(mism), 32'd0);
    check("stream_length", 32'(len), 32'd16384);
    check("done_at_fall", {30'h0, busy, key_done}, 32'h1);
  endtask

  initial begin
    int idle_bad;
    // Reset held for three cycles, then idle with start low.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({R_random, G_random, B_random, Key_ready, busy, key_done} !== 27'h0) idle_bad++;
      if ({R1, G1, B1, kr1, busy1, done1} !== 27'h0) idle_bad++;
    end
    check("reset_idle_outputs", 32'(idle_bad), 32'd0);

    // rst wins over a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_beats_start", {29'h0, Key_ready, busy, key_done}, 32'h0);

    // Short instance: WARMUP=1, NUM_BYTES=4, seeds 1/1.
    seed_lfsr1 = 32'h1;
    seed_x1 = 16'h1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("short_warmup", {30'h0, kr1, busy1}, 32'h1);
    @(negedge clk);
    check("short_ready_rise", 32'(kr1), 32'd1);
    check("short_triple0", {8'h00, R1, G1, B1}, 32'h00238000);
    @(negedge clk);
    check("short_triple1", {8'h00, R1, G1, B1}, 32'h0035C007);
    @(negedge clk);
    @(negedge clk);
    check("short_ready_tail", 32'(kr1), 32'd1);
    @(negedge clk);
    check("short_done", {29'h0, kr1, busy1, done1}, 32'h1);
    check("short_bytes_zero", {8'h00, R1, G1, B1}, 32'h0);

    // Full run with a start pulse mid-stream that must be ignored.
    run(32'hDEADBEEF, 16'h1234, 32'hDEADBEEF, 16'h1234, 5000, -1, csum_a);
    // Restart from DONE with the same seeds.
    run(32'hDEADBEEF, 16'h1234, 32'hDEADBEEF, 16'h1234, -1, -1, csum_b);
    check("restart_identical", csum_b, csum_a);
    // Zero seeds behave as seeds of one.
    run(32'h0, 16'h0, 32'h1, 16'h1, -1, -1, csum_b);
    // Reset at stream cycle 100, then a clean full run.
    run(32'hDEADBEEF, 16'h1234, 32'hDEADBEEF, 16'h1234, -1, 100, csum_b);
    run(32'hDEADBEEF, 16'h1234, 32'hDEADBEEF, 16'h1234, -1, -1, csum_b);
    check("post_reset_identical", csum_b, csum_a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
